// File: rtl/pwm_peripheral_pkg.sv
// Shared constants and helpers for the PWM output peripheral.
package pwm_peripheral_pkg;

    localparam int unsigned PWM_STEPS        = 256;
    localparam logic [7:0]  DUTY_FULL        = 8'hFF;
    localparam int unsigned NUM_CH           = 16;
    localparam int unsigned DEFAULT_PRESCALE = 13;
    localparam int unsigned DEFAULT_CNT_W    = 16;

    // Duty 0xFF is a true 100%; every other value is high for 'duty' of 256 ticks.
    function automatic logic pwm_compare(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == DUTY_FULL) ? 1'b1 : (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler, 8-bit PWM counter and period-boundary duty shadow shared by all channels.
module pwm_timebase
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty_in,
    output logic       pwm_level,
    output logic       period_start
);

    logic [CNT_W-1:0] prescaler;
    logic [7:0]       pwm_cnt;
    logic [7:0]       duty_shadow;
    logic             tick;
    logic             boundary;

    // With PRESCALE == 1 the prescaler sits at 0 and tick is permanently high.
    assign tick     = (prescaler == CNT_W'(PRESCALE - 1));
    assign boundary = tick && (pwm_cnt == 8'hFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + CNT_W'(1);
        end
    end

    // Duty is only sampled on the wrap edge so a period is never cut short or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt      <= '0;
            duty_shadow  <= '0;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (boundary) begin
                duty_shadow <= duty_in;
            end
        end
    end

    assign pwm_level = pwm_compare(pwm_cnt, duty_shadow);

endmodule

// File: rtl/pwm_peripheral.sv
// 16-channel output stage: each channel is forced low, static high, or the shared PWM waveform.
module pwm_peripheral
    import pwm_peripheral_pkg::*;
#(
    parameter int unsigned PRESCALE = DEFAULT_PRESCALE,
    parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
    logic [NUM_CH-1:0] next_out;
    logic              pwm_level;

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    pwm_timebase #(
        .PRESCALE (PRESCALE),
        .CNT_W    (CNT_W)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty_in      (pwm_duty_cycle),
        .pwm_level    (pwm_level),
        .period_start (period_start)
    );

    always_comb begin
        next_out = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            next_out[i] = en_out[i] ? (en_pwm[i] ? pwm_level : 1'b1) : 1'b0;
        end
    end

    // Enable and select are deliberately unshadowed: they reach the pins one clk later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= next_out;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Scoreboard bench: stimulus queues per-period expectations, a monitor checks each closed period.
module tb_pwm_peripheral;

    localparam int PERIOD = 3328;  // 256 * 13 clks

    typedef struct {
        logic [15:0] en_out;
        logic [15:0] en_pwm;
        logic [7:0]  d_start;
        logic [7:0]  d_mid;
        logic [7:0]  d_end;
        int          hi0;
        logic [15:0] and_v;
        logic [15:0] or_v;
    } row_t;

    typedef struct {
        int          len;
        int          hi0;
        logic [15:0] and_v;
        logic [15:0] or_v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    row_t rows[12];

    pwm_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .out             (out),
        .period_start    (period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h (%0d), required 0x%0h (%0d)", name, act, act, req, req);
        end
    endtask

    task automatic apply(input row_t r);
        en_reg_out_7_0  = r.en_out[7:0];
        en_reg_out_15_8 = r.en_out[15:8];
        en_reg_pwm_7_0  = r.en_pwm[7:0];
        en_reg_pwm_15_8 = r.en_pwm[15:8];
        pwm_duty_cycle  = r.d_start;
    endtask

    task automatic push_exp(input int hi0, input logic [15:0] and_v, input logic [15:0] or_v);
        exp_t e;
        e.len   = PERIOD;
        e.hi0   = hi0;
        e.and_v = and_v;
        e.or_v  = or_v;
        exp_q.push_back(e);
    endtask

    task automatic wait_ps();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            @(negedge clk);
            found = period_start;
        end
        check("period_start_arrival", {31'd0, found}, 32'd1);
    endtask

    // Monitor: a window runs from the clk after one period_start through the next pulse,
    // which lines up with the registered out lagging pwm_cnt by one clk.
    int          w_len;
    int          w_hi0;
    logic [15:0] w_and;
    logic [15:0] w_or;
    logic        prev_ps;

    initial begin
        exp_t e;
        w_len = 0; w_hi0 = 0; w_and = '1; w_or = '0; prev_ps = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                w_len = 0; w_hi0 = 0; w_and = '1; w_or = '0; prev_ps = 1'b0;
            end else begin
                w_len++;
                w_hi0 += int'(out[0]);
                w_and &= out;
                w_or  |= out;
                if (period_start) begin
                    check("period_start_single_clk", {31'd0, prev_ps}, 32'd0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_period", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("period_len", w_len, e.len);
                        check("out0_high_clks", w_hi0, e.hi0);
                        check("out_and", {16'd0, w_and}, {16'd0, e.and_v});
                        check("out_or", {16'd0, w_or}, {16'd0, e.or_v});
                    end
                    w_len = 0; w_hi0 = 0; w_and = '1; w_or = '0;
                end
                prev_ps = period_start;
            end
        end
    end

    // Stimulus. Shadow duty of each window equals d_end of the window before it.
    initial begin
        rows[0]  = '{16'h0FA5, 16'h0000, 8'h00, 8'h00, 8'h00, 3328, 16'h0FA5, 16'h0FA5};
        rows[1]  = '{16'h0FA5, 16'h0000, 8'h80, 8'h80, 8'h80, 3328, 16'h0FA5, 16'h0FA5};
        rows[2]  = '{16'hFFFF, 16'h0001, 8'h80, 8'h80, 8'h80, 1664, 16'hFFFE, 16'hFFFF};
        rows[3]  = '{16'hFFFF, 16'h0001, 8'h00, 8'h00, 8'h00, 1664, 16'hFFFE, 16'hFFFF};
        rows[4]  = '{16'hFFFF, 16'h0001, 8'hFF, 8'hFF, 8'hFF,    0, 16'hFFFE, 16'hFFFE};
        rows[5]  = '{16'hFFFF, 16'h0001, 8'hFF, 8'hFF, 8'hFF, 3328, 16'hFFFF, 16'hFFFF};
        rows[6]  = '{16'hFFFF, 16'h0001, 8'h01, 8'h01, 8'h01, 3328, 16'hFFFF, 16'hFFFF};
        rows[7]  = '{16'hFFFF, 16'h0001, 8'h40, 8'h40, 8'h40,   13, 16'hFFFE, 16'hFFFF};
        rows[8]  = '{16'hFFFF, 16'h0001, 8'h40, 8'hC0, 8'hC0,  832, 16'hFFFE, 16'hFFFF};
        rows[9]  = '{16'hFFFF, 16'h0001, 8'hC0, 8'h10, 8'h30, 2496, 16'hFFFE, 16'hFFFF};
        rows[10] = '{16'h00FF, 16'h0F0F, 8'h30, 8'h30, 8'h30,  624, 16'h00F0, 16'h00FF};
        rows[11] = '{16'h8001, 16'h8000, 8'h80, 8'h80, 8'h80, 3328, 16'h0001, 16'h8001};

        rst_n           = 1'b0;
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'h01;
        en_reg_pwm_15_8 = 8'h00;
        pwm_duty_cycle  = 8'hFF;
        repeat (5) @(negedge clk);
        check("reset_out", {16'd0, out}, 32'd0);
        check("reset_period_start", {31'd0, period_start}, 32'd0);

        apply(rows[0]);
        push_exp(rows[0].hi0, rows[0].and_v, rows[0].or_v);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int r = 0; r < 12; r++) begin
            repeat (1600) @(negedge clk);
            pwm_duty_cycle = rows[r].d_mid;
            repeat (PERIOD - 1 - 1600) @(negedge clk);
            pwm_duty_cycle = rows[r].d_end;  // present on the boundary edge itself
            wait_ps();
            if (r < 11) begin
                apply(rows[r + 1]);
                push_exp(rows[r + 1].hi0, rows[r + 1].and_v, rows[r + 1].or_v);
            end
        end

        // Mid-period reset during the high phase of a 50% waveform.
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'h01;
        en_reg_pwm_15_8 = 8'h00;
        pwm_duty_cycle  = 8'h80;
        repeat (100) @(negedge clk);
        check("pre_reset_out", {16'd0, out}, 32'h0000FFFF);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_out", {16'd0, out}, 32'd0);
        check("async_reset_period_start", {31'd0, period_start}, 32'd0);
        repeat (3) @(negedge clk);
        check("held_reset_out", {16'd0, out}, 32'd0);
        push_exp(0, 16'hFFFE, 16'hFFFE);
        #2 rst_n = 1'b1;
        repeat (PERIOD - 1) @(negedge clk);
        wait_ps();
        push_exp(1664, 16'hFFFE, 16'hFFFF);
        repeat (PERIOD - 1) @(negedge clk);
        wait_ps();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout at %0t, required completion", $time);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
